// File: rtl/button_press_decoder.sv
// Button front end: 2-flop synchronizer, debouncer and short/long press classifier.
// Optional auto-repeat while a long press is held is built when PRESS_REPEAT_EN is defined.
module button_press_decoder #(
  parameter int DEBOUNCE_CYCLES = 240_000,
  parameter int LONG_CYCLES     = 24_000_000,
  parameter int REPEAT_CYCLES   = 6_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       button_in,
  output logic       held,
  output logic       pressed_pulse,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic [1:0] o_dbg_state
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  // Pin level that means "not pressed"; synchronizer flops reset to it.
  localparam logic REL_LVL = ACTIVE_LOW;

  generate
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 1) begin : g_bad_params
      $error("button_press_decoder: illegal cycle parameters");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_HELD_SHORT = 2'd1,
    ST_HELD_LONG  = 2'd2
  } state_t;

  logic              r_sync1, r_sync2;
  logic              w_pressed;
  logic              r_db;
  logic [DB_W-1:0]   r_db_cnt;
  state_t            r_state, w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
  logic              w_press_nxt, w_short_nxt, w_long_nxt, w_repeat_nxt;
  logic              r_held, r_press, r_short, r_long, r_repeat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= REL_LVL;
      r_sync2 <= REL_LVL;
    end else begin
      r_sync1 <= button_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ACTIVE_LOW ? ~r_sync2 : r_sync2;

  // Any cycle of agreement restarts the count, so only an unbroken run of
  // DEBOUNCE_CYCLES mismatching cycles moves the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db     <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_pressed != r_db) begin
      if (r_db_cnt == DB_LAST) begin
        r_db     <= w_pressed;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end else begin
      r_db_cnt <= '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_press_nxt = 1'b0;
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_state)
      ST_RELEASED: begin
        if (r_db) begin
          w_state_nxt = ST_HELD_SHORT;
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
        end
      end
      ST_HELD_SHORT: begin
        // Release is checked first so it wins over a coincident long threshold.
        if (!r_db) begin
          w_state_nxt = ST_RELEASED;
          w_short_nxt = 1'b1;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_nxt = ST_HELD_LONG;
          w_long_nxt  = 1'b1;
        end else if (r_hold_cnt != HOLD_MAX) begin
          w_hold_nxt = r_hold_cnt + HOLD_W'(1);
        end
      end
      ST_HELD_LONG: begin
        if (!r_db) begin
          w_state_nxt = ST_RELEASED;
        end
      end
      default: begin
        w_state_nxt = ST_RELEASED;
      end
    endcase
  end

`ifdef PRESS_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] r_rep_cnt, w_rep_nxt;

  // Held at 0 until the long hold, so the first repeat lands one full period after long_pulse.
  always_comb begin
    w_rep_nxt    = r_rep_cnt;
    w_repeat_nxt = 1'b0;
    if (r_state != ST_HELD_LONG) begin
      w_rep_nxt = '0;
    end else if (r_db) begin
      if (r_rep_cnt == REP_LAST) begin
        w_repeat_nxt = 1'b1;
        w_rep_nxt    = '0;
      end else begin
        w_rep_nxt = r_rep_cnt + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rep_cnt <= '0;
    else        r_rep_cnt <= w_rep_nxt;
  end
`else
  assign w_repeat_nxt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_RELEASED;
      r_hold_cnt <= '0;
      r_held     <= 1'b0;
      r_press    <= 1'b0;
      r_short    <= 1'b0;
      r_long     <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_held     <= (w_state_nxt != ST_RELEASED);
      r_press    <= w_press_nxt;
      r_short    <= w_short_nxt;
      r_long     <= w_long_nxt;
      r_repeat   <= w_repeat_nxt;
    end
  end

  assign held          = r_held;
  assign pressed_pulse = r_press;
  assign short_pulse   = r_short;
  assign long_pulse    = r_long;
  assign repeat_pulse  = r_repeat;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_button_press_decoder.sv
// Bench for button_press_decoder: table of press lengths checked cycle by cycle
// against a timing model, plus reset and reset-mid-press sequences.
module tb_button_press_decoder;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;
`ifdef PRESS_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button_in = 1'b1;
  logic       held, pressed_pulse, short_pulse, long_pulse, repeat_pulse;
  logic [1:0] o_dbg_state;
  logic [4:0] act;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    string name;
    int    len;
    int    e_press;
    int    e_short;
    int    e_long;
    int    e_rep;
  } vec_t;
  vec_t vecs[8];

  button_press_decoder #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LONG),
    .REPEAT_CYCLES  (REP),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .button_in    (button_in),
    .held         (held),
    .pressed_pulse(pressed_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .o_dbg_state  (o_dbg_state)
  );

  always #5 clk = ~clk;

  assign act = {held, pressed_pulse, short_pulse, long_pulse, repeat_pulse};

  // Expected {held,press,short,long,repeat} after posedge n, pin low during edges 1..len.
  function automatic logic [4:0] exp_vec(input int len, input int n);
    int   p, r;
    logic ok, h, pp, sp, lp, rp;
    ok = (len >= DB);
    p  = 3 + DB;
    r  = len + p;
    h  = ok && (n >= p) && (n < r);
    pp = ok && (n == p);
    sp = ok && (n == r) && (len <= LONG);
    lp = ok && (len > LONG) && (n == p + LONG);
    rp = (REP_ON != 0) && ok && (len > LONG) && (n > p + LONG) && (n < r) &&
         (((n - p - LONG) % REP) == 0);
    return {h, pp, sp, lp, rp};
  endfunction

  task automatic check_vec(input string name, input int n, input logic [4:0] e);
    n_tests++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s n=%0d got=%b want=%b (held,press,short,long,repeat)", name, n, act, e);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, a, e);
    end
  endtask

  // Starts and ends just after a negedge; drives the pin for the next posedge.
  task automatic run_scn(input string name, input int len, input int n_stop,
                         output int c_press, output int c_short,
                         output int c_long, output int c_rep);
    logic [4:0] e;
    c_press = 0; c_short = 0; c_long = 0; c_rep = 0;
    for (int n = 1; n <= n_stop; n++) exp_q.push_back(exp_vec(len, n));
    button_in = (len >= 1) ? 1'b0 : 1'b1;
    for (int n = 1; n <= n_stop; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s n=%0d scoreboard empty", name, n);
      end else begin
        e = exp_q.pop_front();
        check_vec(name, n, e);
      end
      c_press += int'(pressed_pulse);
      c_short += int'(short_pulse);
      c_long  += int'(long_pulse);
      c_rep   += int'(repeat_pulse);
      button_in = (n + 1 <= len) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int cp, cs, cl, cr;

    vecs[0] = '{"short10",   10, 1, 1, 0, 0};
    vecs[1] = '{"glitch3",    3, 0, 0, 0, 0};
    vecs[2] = '{"glitch2",    2, 0, 0, 0, 0};
    vecs[3] = '{"min4",       4, 1, 1, 0, 0};
    vecs[4] = '{"long40",    40, 1, 0, 1, 3 * REP_ON};
    vecs[5] = '{"edge20",    20, 1, 1, 0, 0};
    vecs[6] = '{"long21",    21, 1, 0, 1, 0};
    vecs[7] = '{"long25",    25, 1, 0, 1, 0};

    // Reset held with a toggling pin: outputs stay 0.
    rst_n = 1'b0;
    button_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      button_in = 1'($urandom_range(0, 1));
      check_vec("reset_hold", i, 5'b0);
    end
    @(negedge clk);
    button_in = 1'b1;
    rst_n = 1'b1;
    run_scn("post_reset", 0, 12, cp, cs, cl, cr);

    foreach (vecs[i]) begin
      run_scn(vecs[i].name, vecs[i].len, vecs[i].len + 12, cp, cs, cl, cr);
      check_int({vecs[i].name, "_press_cnt"}, cp, vecs[i].e_press);
      check_int({vecs[i].name, "_short_cnt"}, cs, vecs[i].e_short);
      check_int({vecs[i].name, "_long_cnt"},  cl, vecs[i].e_long);
      check_int({vecs[i].name, "_rep_cnt"},   cr, vecs[i].e_rep);
    end

    // Reset during HELD_SHORT with the pin kept low.
    run_scn("midpress_pre", 100, 12, cp, cs, cl, cr);
    rst_n = 1'b0;
    #1;
    check_vec("midpress_rst_now", 0, 5'b0);
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      check_vec("midpress_rst_hold", i, 5'b0);
    end
    rst_n = 1'b1;
    run_scn("midpress_post", 10, 22, cp, cs, cl, cr);
    check_int("midpress_post_press_cnt", cp, 1);
    check_int("midpress_post_short_cnt", cs, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_press_decoder.md
# button_press_decoder

Front-end button conditioning stage that sits directly upstream of the LED/password controller and replaces its bare debounce pulse. It synchronizes a raw board button, debounces it, and classifies each press as short or long, emitting single-cycle event pulses. An optional auto-repeat feature emits periodic pulses while a long press is held.

## Interface
- DEBOUNCE_CYCLES, 240_000: consecutive stable cycles before the debounced level changes (10 ms @ 24 MHz); must be ≥ 2.
- LONG_CYCLES, 24_000_000: hold duration, in cycles, that classifies a press as long (1 s @ 24 MHz); must be > DEBOUNCE_CYCLES.
- REPEAT_CYCLES, 6_000_000: auto-repeat period in HELD_LONG (used only with PRESS_REPEAT_EN).
- ACTIVE_LOW, 1: 1 means raw pin low = pressed; 0 means raw pin high = pressed.
- clk  input  1  system clock (24 MHz); single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- button_in  input  1  raw, asynchronous button pin.
- held  output  1  debounced logical pressed level.
- pressed_pulse  output  1  one cycle on each debounced press.
- short_pulse  output  1  one cycle on release of a press shorter than LONG_CYCLES.
- long_pulse  output  1  one cycle when a hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one cycle per REPEAT_CYCLES while in HELD_LONG; constant 0 without PRESS_REPEAT_EN.

## Operation
- Input path: button_in → 2-flop synchronizer → polarity normalization (pressed = 1) → debouncer → FSM.
- Debouncer: the counter increments on every cycle where the synchronized level ≠ db, and clears to 0 on any cycle where they are equal. When the counter is at DEBOUNCE_CYCLES-1 and a mismatch is still present, db takes the synchronized value and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES cycles never change db.
- FSM states: RELEASED, HELD_SHORT, HELD_LONG.
- RELEASED → HELD_SHORT on the db rising edge: pressed_pulse = 1 and hold_cnt ← 0.
- HELD_SHORT: hold_cnt increments each cycle.
  - When hold_cnt = LONG_CYCLES-1: long_pulse = 1, go to HELD_LONG, rep_cnt ← 0.
  - On the db falling edge: short_pulse = 1, go to RELEASED.
  - If both happen in the same cycle, release wins: short_pulse only, no long_pulse.
- HELD_LONG → RELEASED on the db falling edge, with no short_pulse.
- held = 1 exactly in HELD_SHORT and HELD_LONG.
- Counter widths are $clog2(max+1) of their limit.
  - hold_cnt saturates and never wraps.
  - rep_cnt wraps to 0 after each repeat_pulse.
- Reset is asynchronous and active-low.
  - Synchronizer flops and db reset to the released level.
  - All counters reset to 0 and the FSM resets to RELEASED.
  - All outputs reset to 0.
- Reset mid-press: no release event is emitted. If the pin is still pressed when rst_n deasserts, a fresh pressed_pulse follows after the normal debounce latency.

## Timing
- All outputs are registered; every pulse is exactly one clk cycle wide.
- Press latency: a stable press that begins before clock edge k gives held = 1 and pressed_pulse = 1 in the cycle after edge k+2+DEBOUNCE_CYCLES (2 synchronizer cycles plus debounce).
- Release latency is the same; short_pulse coincides with the cycle in which held falls.
- long_pulse is asserted LONG_CYCLES cycles after pressed_pulse.
- First repeat_pulse is REPEAT_CYCLES cycles after long_pulse, then every REPEAT_CYCLES cycles.
- Pulses never overlap, except that pressed_pulse and held rise in the same cycle.

## Configuration
- PRESS_REPEAT_EN defined: rep_cnt and repeat_pulse behave as described above.
- PRESS_REPEAT_EN undefined: rep_cnt is not built and repeat_pulse is tied to 0. The port stays present and all other behaviour is identical.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, ACTIVE_LOW=1.
- Reset: hold rst_n=0 with button_in toggling → all outputs 0 throughout; after release with the pin high, nothing fires.
- Short press: drive button_in low for 10 cycles → pressed_pulse 6 cycles after the falling edge; short_pulse when held falls; long_pulse never asserts.
- Glitch: drive button_in low for 3 cycles, then high → held and all pulses stay 0.
- Long press: drive button_in low for 40 cycles → long_pulse exactly 20 cycles after pressed_pulse; short_pulse stays 0 on release.
- Repeat (PRESS_REPEAT_EN defined): same 40-cycle stimulus → repeat_pulse at +5, +10 and +15 after long_pulse, stopping at release. With the macro undefined → repeat_pulse stays 0.
- Reset mid-press: assert rst_n=0 during HELD_SHORT while the pin stays low → outputs clear immediately; a new pressed_pulse arrives 6 cycles after rst_n rises.
